// File: rtl/con_ctrl_pkg.sv
// Shared states, error codes and width helper for the console dispatcher.
package con_ctrl_pkg;

  localparam int unsigned CON_ST_W = 4;

  typedef enum logic [CON_ST_W-1:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } con_state_e;

  localparam logic [1:0] CON_ERR_NONE  = 2'b00;
  localparam logic [1:0] CON_ERR_RANGE = 2'b01;
  localparam logic [1:0] CON_ERR_TMO   = 2'b10;
  localparam logic [1:0] CON_ERR_HND   = 2'b11;

  function automatic int unsigned con_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/con_area_decode.sv
// Comparator chain mapping a console address to its area index and area-relative offset.
module con_area_decode
  import con_ctrl_pkg::*;
#(
  parameter int unsigned N_AREA = 4,
  parameter int unsigned ADDR_W = 10,
  parameter logic [N_AREA*ADDR_W-1:0] AREA_BOUNDS = {10'd408, 10'd400, 10'd128, 10'd64},
  parameter int unsigned IDX_W  = con_idx_w(N_AREA)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit_c,
  output logic [IDX_W-1:0]  o_idx_c,
  output logic [ADDR_W-1:0] o_offset_c
);

  logic [ADDR_W-1:0] w_hi [N_AREA];
  logic [ADDR_W-1:0] w_lo [N_AREA];

  for (genvar g = 0; g < N_AREA; g++) begin : g_bound
    assign w_hi[g] = AREA_BOUNDS[g*ADDR_W +: ADDR_W];
    if (g == 0) begin : g_first
      assign w_lo[g] = '0;
    end else begin : g_rest
      assign w_lo[g] = AREA_BOUNDS[(g-1)*ADDR_W +: ADDR_W];
    end
  end

  // Scan from the top so the lowest matching area is the one that sticks.
  always_comb begin
    o_hit_c    = 1'b0;
    o_idx_c    = '0;
    o_offset_c = '0;
    for (int k = int'(N_AREA) - 1; k >= 0; k--) begin
      if (i_addr < w_hi[k]) begin
        o_hit_c    = 1'b1;
        o_idx_c    = IDX_W'(k);
        o_offset_c = i_addr - w_lo[k];
      end
    end
  end

endmodule

// File: rtl/con_ctrl_dispatch.sv
// Console-access dispatcher: decode, one-cycle handler start, wait with watchdog,
// single done/error response pulse.
module con_ctrl_dispatch
  import con_ctrl_pkg::*;
#(
  parameter int unsigned N_AREA      = 4,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [N_AREA*ADDR_W-1:0] AREA_BOUNDS = {10'd408, 10'd400, 10'd128, 10'd64},
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TMO_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start_con,
  input  logic [ADDR_W-1:0]              im_base_addr,
  output logic                           o_done_con,
  output logic                           o_error_con,
  output logic [1:0]                     o_err_code,
  output logic                           o_busy,
  output logic [con_idx_w(N_AREA)-1:0]   o_area_idx,
  output logic [ADDR_W-1:0]              om_base_addr,
  output logic [ADDR_W-1:0]              om_offset,
  output logic [N_AREA-1:0]              o_start,
  input  logic [N_AREA-1:0]              i_done,
  input  logic [N_AREA-1:0]              i_error
);

  localparam int unsigned IDX_W = con_idx_w(N_AREA);
  localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(TIMEOUT_CYC);

  con_state_e          r_state, w_state_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic [1:0]          r_err, w_err_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [ADDR_W-1:0]   r_off, w_off_nxt;
  logic [N_AREA-1:0]   r_start, w_start_nxt;
  logic [TMO_W-1:0]    r_wdog, w_wdog_nxt;

  logic                w_dec_hit;
  logic [IDX_W-1:0]    w_dec_idx;
  logic [ADDR_W-1:0]   w_dec_off;
  logic                w_tmo;

  con_area_decode #(
    .N_AREA      (N_AREA),
    .ADDR_W      (ADDR_W),
    .AREA_BOUNDS (AREA_BOUNDS),
    .IDX_W       (IDX_W)
  ) u_decode (
    .i_addr     (im_base_addr),
    .o_hit_c    (w_dec_hit),
    .o_idx_c    (w_dec_idx),
    .o_offset_c (w_dec_off)
  );

  // Fires in the WAIT cycle that would be the TIMEOUT_CYC-th one.
  assign w_tmo = (TIMEOUT_CYC != 0) && (({1'b0, r_wdog} + (TMO_W+1)'(1)) == TMO_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_idx_nxt   = r_idx;
    w_base_nxt  = r_base;
    w_off_nxt   = r_off;
    w_start_nxt = '0;
    w_wdog_nxt  = r_wdog;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start_con) begin
          w_busy_nxt = 1'b1;
          w_base_nxt = im_base_addr;
          w_idx_nxt  = w_dec_idx;
          w_off_nxt  = w_dec_off;
          if (w_dec_hit) begin
            w_err_nxt   = CON_ERR_NONE;
            w_start_nxt = N_AREA'(1) << w_dec_idx;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_err_nxt   = CON_ERR_RANGE;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_error[r_idx]) begin
          w_err_nxt   = CON_ERR_HND;
          w_error_nxt = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (i_done[r_idx]) begin
          w_err_nxt   = CON_ERR_NONE;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_tmo) begin
          w_err_nxt   = CON_ERR_TMO;
          w_error_nxt = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_wdog != {TMO_W{1'b1}}) begin
          w_wdog_nxt = r_wdog + TMO_W'(1);
        end
      end
      ST_RESP: begin
        // Out-of-range entries arrive without a pulse armed; emit it one cycle later.
        if (r_done || r_error) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_done_nxt  = (r_err == CON_ERR_NONE);
          w_error_nxt = (r_err != CON_ERR_NONE);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_err   <= CON_ERR_NONE;
      r_idx   <= '0;
      r_base  <= '0;
      r_off   <= '0;
      r_start <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_err   <= w_err_nxt;
      r_idx   <= w_idx_nxt;
      r_base  <= w_base_nxt;
      r_off   <= w_off_nxt;
      r_start <= w_start_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  assign o_done_con   = r_done;
  assign o_error_con  = r_error;
  assign o_err_code   = r_err;
  assign o_busy       = r_busy;
  assign o_area_idx   = r_idx;
  assign om_base_addr = r_base;
  assign om_offset    = r_off;
  assign o_start      = r_start;

endmodule

// File: tb/tb_con_ctrl_dispatch.sv
// Randomized self-checking bench for con_ctrl_dispatch against a transaction-level model.
module tb_con_ctrl_dispatch;

  localparam int unsigned N_AREA  = 4;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start_con;
  logic [ADDR_W-1:0] im_base_addr;
  logic              o_done_con;
  logic              o_error_con;
  logic [1:0]        o_err_code;
  logic              o_busy;
  logic [1:0]        o_area_idx;
  logic [ADDR_W-1:0] om_base_addr;
  logic [ADDR_W-1:0] om_offset;
  logic [N_AREA-1:0] o_start;
  logic [N_AREA-1:0] i_done;
  logic [N_AREA-1:0] i_error;

  int n_checks = 0;
  int n_errors = 0;
  int bounds [4] = '{64, 128, 400, 408};

  con_ctrl_dispatch #(
    .N_AREA      (N_AREA),
    .ADDR_W      (ADDR_W),
    .AREA_BOUNDS ({10'd408, 10'd400, 10'd128, 10'd64}),
    .TIMEOUT_CYC (TIMEOUT),
    .TMO_W       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start_con  (i_start_con),
    .im_base_addr (im_base_addr),
    .o_done_con   (o_done_con),
    .o_error_con  (o_error_con),
    .o_err_code   (o_err_code),
    .o_busy       (o_busy),
    .o_area_idx   (o_area_idx),
    .om_base_addr (om_base_addr),
    .om_offset    (om_offset),
    .o_start      (o_start),
    .i_done       (i_done),
    .i_error      (i_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Area k covers [bound k-1, bound k); above the last bound is out of range.
  function automatic void model_decode(input int addr, output bit hit, output int idx, output int off);
    hit = 1'b0; idx = 0; off = 0;
    for (int k = 0; k < 4; k++) begin
      if (!hit && addr < bounds[k]) begin
        hit = 1'b1;
        idx = k;
        off = addr - ((k == 0) ? 0 : bounds[k-1]);
      end
    end
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_done"},  32'(o_done_con),  32'd0);
    check_eq({tag, "_error"}, 32'(o_error_con), 32'd0);
  endtask

  // kind: 0 done, 1 error, 2 done+error, 3 no strobe. delay = WAIT cycle of the strobe.
  task automatic run_req(input int addr, input int delay, input int kind, input bit noise);
    bit hit; int idx, off, jeff, code;
    logic [N_AREA-1:0] sel;
    model_decode(addr, hit, idx, off);
    sel = N_AREA'(1) << idx;
    @(negedge clk);
    i_start_con  = 1'b1;
    im_base_addr = ADDR_W'(addr);
    @(negedge clk);
    i_start_con  = 1'b0;
    im_base_addr = ADDR_W'($urandom);
    check_eq("t1_busy", 32'(o_busy), 32'd1);
    check_eq("t1_base", 32'(om_base_addr), 32'(addr));
    check_quiet("t1");
    if (!hit) begin
      check_eq("rng_code", 32'(o_err_code), 32'd1);
      check_eq("rng_nostart", 32'(o_start), 32'd0);
      @(negedge clk);
      check_eq("rng_error", 32'(o_error_con), 32'd1);
      check_eq("rng_done", 32'(o_done_con), 32'd0);
      check_eq("rng_nostart2", 32'(o_start), 32'd0);
      check_eq("rng_busy", 32'(o_busy), 32'd1);
      @(negedge clk);
      check_quiet("rng_after");
      check_eq("rng_idle", 32'(o_busy), 32'd0);
      check_eq("rng_hold", 32'(o_err_code), 32'd1);
      return;
    end
    check_eq("issue_start", 32'(o_start), 32'(sel));
    check_eq("issue_idx", 32'(o_area_idx), 32'(idx));
    check_eq("issue_off", 32'(om_offset), 32'(off));
    check_eq("issue_code", 32'(o_err_code), 32'd0);
    if (kind == 3 || delay > int'(TIMEOUT)) begin
      jeff = TIMEOUT; code = 2;
    end else begin
      jeff = delay; code = (kind == 0) ? 0 : 3;
    end
    for (int j = 1; j <= jeff; j++) begin
      @(negedge clk);
      check_eq("wait_start", 32'(o_start), 32'd0);
      check_eq("wait_busy", 32'(o_busy), 32'd1);
      check_quiet("wait");
      if (noise) begin
        i_done       = ~sel;
        i_error      = N_AREA'($urandom) & ~sel;
        i_start_con  = 1'b1;
        im_base_addr = ADDR_W'($urandom);
      end else begin
        i_done = '0; i_error = '0;
      end
      if (j == jeff && code != 2) begin
        if (kind == 0 || kind == 2) i_done  = i_done | sel;
        if (kind == 1 || kind == 2) i_error = i_error | sel;
      end
    end
    @(negedge clk);
    i_done = '0; i_error = '0; i_start_con = 1'b0;
    check_eq("resp_done", 32'(o_done_con), 32'(code == 0));
    check_eq("resp_error", 32'(o_error_con), 32'(code != 0));
    check_eq("resp_code", 32'(o_err_code), 32'(code));
    check_eq("resp_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    check_quiet("post");
    check_eq("post_busy", 32'(o_busy), 32'd0);
    check_eq("post_code_hold", 32'(o_err_code), 32'(code));
    check_eq("post_base_hold", 32'(om_base_addr), 32'(addr));
    check_eq("post_off_hold", 32'(om_offset), 32'(off));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_done"},  32'(o_done_con), 32'd0);
    check_eq({tag, "_error"}, 32'(o_error_con), 32'd0);
    check_eq({tag, "_code"},  32'(o_err_code), 32'd0);
    check_eq({tag, "_busy"},  32'(o_busy), 32'd0);
    check_eq({tag, "_idx"},   32'(o_area_idx), 32'd0);
    check_eq({tag, "_base"},  32'(om_base_addr), 32'd0);
    check_eq({tag, "_off"},   32'(om_offset), 32'd0);
    check_eq({tag, "_start"}, 32'(o_start), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_start_con = 1'b0; im_base_addr = '0; i_done = '0; i_error = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    run_req(10, 3, 0, 1'b0);
    run_req(200, 2, 2, 1'b0);
    run_req(450, 0, 0, 1'b0);
    run_req(70, 5, 3, 1'b0);
    run_req(403, 4, 0, 1'b1);
    run_req(64, 1, 0, 1'b0);
    run_req(407, 16, 0, 1'b0);
    run_req(127, 17, 1, 1'b0);
    run_req(408, 0, 0, 1'b0);
    run_req(399, 2, 1, 1'b1);

    // Reset during WAIT drops the request silently.
    @(negedge clk);
    i_start_con = 1'b1; im_base_addr = ADDR_W'(300);
    @(negedge clk);
    i_start_con = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst_idle");
    run_req(130, 2, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_req(int'($urandom_range(0, 511)), int'($urandom_range(1, 20)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
